// File: rtl/gnn_pkg.sv
// gnn_pkg: shared sizes, state encoding and
// helpers for the graph feature aggregator.
package gnn_pkg;

  localparam int NUM_NODES = 4;
  localparam int FEAT_N    = 4;
  localparam int RELU_W    = 15;
  localparam int AGGR_W    = 17;
  localparam int ID_W      = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Negative features must never reach the sums.
  function automatic logic [RELU_W-1:0] relu_clamp(
    input logic [RELU_W-1:0] v
  );
    return v[RELU_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/gnn_aggr_sum.sv
// gnn_aggr_sum: masked sum of four non-negative
// features, zero-extended to the aggregate width.
module gnn_aggr_sum
  import gnn_pkg::*;
(
  input  logic [RELU_W-1:0] src0_i,
  input  logic [RELU_W-1:0] src1_i,
  input  logic [RELU_W-1:0] src2_i,
  input  logic [RELU_W-1:0] src3_i,
  input  logic [3:0]        mask_i,
  output logic [AGGR_W-1:0] sum_o
);

  logic [AGGR_W-1:0] t0;
  logic [AGGR_W-1:0] t1;
  logic [AGGR_W-1:0] t2;
  logic [AGGR_W-1:0] t3;

  // Gate each source by its adjacency bit, then add.
  always_comb begin
    t0    = mask_i[0] ? AGGR_W'(src0_i) : '0;
    t1    = mask_i[1] ? AGGR_W'(src1_i) : '0;
    t2    = mask_i[2] ? AGGR_W'(src2_i) : '0;
    t3    = mask_i[3] ? AGGR_W'(src3_i) : '0;
    sum_o = t0 + t1 + t2 + t3;
  end

endmodule

// File: rtl/gnn_aggregator.sv
// gnn_aggregator: collects one feature vector per
// node, then emits adjacency-weighted sums per node.
module gnn_aggregator #(
  parameter int          NUM_NODES = gnn_pkg::NUM_NODES,
  parameter logic [15:0] ADJ_RESET = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         in_node_id,
  input  logic signed [14:0] y4_relu,
  input  logic signed [14:0] y5_relu,
  input  logic signed [14:0] y6_relu,
  input  logic signed [14:0] y7_relu,
  output logic               in_ready,
  input  logic               adj_load,
  input  logic [15:0]        adj_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_node_id,
  output logic signed [16:0] y4_aggr,
  output logic signed [16:0] y5_aggr,
  output logic signed [16:0] y6_aggr,
  output logic signed [16:0] y7_aggr,
  output logic               frame_done
);

  localparam int FEAT_N = gnn_pkg::FEAT_N;
  localparam int RELU_W = gnn_pkg::RELU_W;
  localparam int AGGR_W = gnn_pkg::AGGR_W;
  localparam logic [1:0] LAST_DST = 2'(NUM_NODES - 1);

  typedef gnn_pkg::state_e state_e;

  typedef logic [FEAT_N-1:0][NUM_NODES-1:0][RELU_W-1:0] buf_t;
  typedef logic [FEAT_N-1:0][AGGR_W-1:0] aggr_t;

  state_e                state_q, state_d;
  logic [NUM_NODES-1:0]  recv_q, recv_d;
  logic [1:0]            dst_q, dst_d;
  buf_t                  buf_q, buf_d;
  logic [15:0]           adj_sh_q, adj_sh_d;
  logic [15:0]           adj_act_q, adj_act_d;
  logic                  oval_q, oval_d;
  logic [1:0]            oid_q, oid_d;
  aggr_t                 aggr_q, aggr_d;
  logic                  done_q, done_d;

  logic [FEAT_N-1:0][RELU_W-1:0] feat_in;
  aggr_t                         sum;
  logic [3:0]                    row;

  assign feat_in[0] = y4_relu;
  assign feat_in[1] = y5_relu;
  assign feat_in[2] = y6_relu;
  assign feat_in[3] = y7_relu;

  assign row = adj_act_q[{dst_q, 2'b00} +: 4];

  for (genvar f = 0; f < FEAT_N; f++) begin : g_sum
    gnn_aggr_sum u_sum (
      .src0_i (buf_q[f][0]),
      .src1_i (buf_q[f][1]),
      .src2_i (buf_q[f][2]),
      .src3_i (buf_q[f][3]),
      .mask_i (row),
      .sum_o  (sum[f])
    );
  end

  assign in_ready    = (state_q == gnn_pkg::COLLECT);
  assign out_valid   = oval_q;
  assign out_node_id = oid_q;
  assign y4_aggr     = aggr_q[0];
  assign y5_aggr     = aggr_q[1];
  assign y6_aggr     = aggr_q[2];
  assign y7_aggr     = aggr_q[3];
  assign frame_done  = done_q;

  // Next-state: capture, per-destination sum, emit.
  always_comb begin
    state_d   = state_q;
    recv_d    = recv_q;
    dst_d     = dst_q;
    buf_d     = buf_q;
    adj_sh_d  = adj_load ? adj_data : adj_sh_q;
    adj_act_d = adj_act_q;
    oval_d    = oval_q;
    oid_d     = oid_q;
    aggr_d    = aggr_q;
    done_d    = 1'b0;
    unique case (state_q)
      gnn_pkg::COLLECT: begin
        if (in_valid) begin
          for (int f = 0; f < FEAT_N; f++) begin
            buf_d[f][in_node_id] =
              gnn_pkg::relu_clamp(feat_in[f]);
          end
          recv_d[in_node_id] = 1'b1;
        end
        if (&recv_q) begin
          state_d   = gnn_pkg::COMPUTE;
          adj_act_d = adj_sh_d;
          dst_d     = '0;
        end
      end
      gnn_pkg::COMPUTE: begin
        aggr_d  = sum;
        oid_d   = dst_q;
        oval_d  = 1'b1;
        state_d = gnn_pkg::EMIT;
      end
      gnn_pkg::EMIT: begin
        if (out_ready) begin
          oval_d = 1'b0;
          if (dst_q == LAST_DST) begin
            state_d = gnn_pkg::COLLECT;
            recv_d  = '0;
            done_d  = 1'b1;
          end else begin
            dst_d   = dst_q + 2'd1;
            state_d = gnn_pkg::COMPUTE;
          end
        end
      end
      default: begin
        state_d = gnn_pkg::COLLECT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= gnn_pkg::COLLECT;
      recv_q    <= '0;
      dst_q     <= '0;
      buf_q     <= '0;
      adj_sh_q  <= ADJ_RESET;
      adj_act_q <= ADJ_RESET;
      oval_q    <= 1'b0;
      oid_q     <= '0;
      aggr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      recv_q    <= recv_d;
      dst_q     <= dst_d;
      buf_q     <= buf_d;
      adj_sh_q  <= adj_sh_d;
      adj_act_q <= adj_act_d;
      oval_q    <= oval_d;
      oid_q     <= oid_d;
      aggr_q    <= aggr_d;
      done_q    <= done_d;
    end
  end

endmodule
